// File: rtl/mips_shift_issue.sv
// MIPS32 shift issue/execute: decode -> stage-1 reg -> barrel shifter -> stage-2 reg; 2-cycle latency.
// Full throughput; stalls ripple back through in_ready (combinational on out_ready), no bubbles or loss.

module mips32_shift (
  input  logic [1:0]  shift_op,
  input  logic [4:0]  shift_amount,
  input  logic [31:0] shift_in,
  output logic [31:0] shift_out
);

  logic [63:0] rot_dbl;

  always_comb begin
    rot_dbl   = {shift_in, shift_in} >> shift_amount;
    shift_out = '0;
    case (shift_op)
      2'b00:   shift_out = shift_in << shift_amount;
      2'b01:   shift_out = shift_in >> shift_amount;
      2'b10:   shift_out = $unsigned($signed(shift_in) >>> shift_amount);
      default: shift_out = rot_dbl[31:0];
    endcase
  end

endmodule

module mips_shift_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired
);

  logic [1:0]       dec_op;
  logic [4:0]       dec_amt;
  logic             dec_ill;

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q;
  logic [4:0]       s1_amt_q;
  logic [31:0]      s1_rt_q;
  logic [4:0]       s1_rd_q;
  logic             s1_ill_q;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [4:0]       out_rd_q;
  logic             out_ill_q;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             s1_adv, s2_adv;
  logic [31:0]      shift_res;

  // Only SPECIAL-opcode shift functs are legal; rs[5+] never influences the amount.
  always_comb begin
    dec_op  = 2'b00;
    dec_amt = in_instr[10:6];
    dec_ill = 1'b1;
    if (in_instr[31:26] == 6'd0) begin
      case (in_instr[5:0])
        6'b000000: begin dec_op = 2'b00; dec_ill = 1'b0; end
        6'b000010: begin dec_op = in_instr[21] ? 2'b11 : 2'b01; dec_ill = 1'b0; end
        6'b000011: begin dec_op = 2'b10; dec_ill = 1'b0; end
        6'b000100: begin dec_op = 2'b00; dec_amt = in_rs[4:0]; dec_ill = 1'b0; end
        6'b000110: begin dec_op = in_instr[6] ? 2'b11 : 2'b01; dec_amt = in_rs[4:0]; dec_ill = 1'b0; end
        6'b000111: begin dec_op = 2'b10; dec_amt = in_rs[4:0]; dec_ill = 1'b0; end
        default:   dec_ill = 1'b1;
      endcase
    end
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  mips32_shift u_shift (
    .shift_op     (s1_op_q),
    .shift_amount (s1_amt_q),
    .shift_in     (s1_rt_q),
    .shift_out    (shift_res)
  );

  always_comb begin
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
    out_data_d = s1_ill_q ? 32'd0 : shift_res;
    retired_d  = retired_q + CNT_W'(out_valid_q && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_amt_q   <= '0;
      s1_rt_q    <= '0;
      s1_rd_q    <= '0;
      s1_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_adv && in_valid) begin
        s1_op_q  <= dec_op;
        s1_amt_q <= dec_amt;
        s1_rt_q  <= in_rt;
        s1_rd_q  <= in_instr[15:11];
        s1_ill_q <= dec_ill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_ill_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      retired_q   <= retired_d;
      // Payload only moves with a valid stage-1 entry, so a stalled result stays put.
      if (s2_adv && s1_valid_q) begin
        out_data_q <= out_data_d;
        out_rd_q   <= s1_rd_q;
        out_ill_q  <= s1_ill_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_ill_q;
  assign retired     = retired_q;

endmodule

// File: doc/mips_shift_issue.md
# mips_shift_issue

Two-stage pipelined issue/execute stage for MIPS32 shift instructions, placed directly upstream of the combinational `mips32_shift` barrel shifter, which it instantiates. It accepts a SPECIAL-opcode instruction word plus register-file operands over a valid/ready handshake and decodes them into `shift_op`/`shift_amount`/`shift_in`. It registers the shifter result with the destination register number for writeback.

## Interface

Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: upstream presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `in_instr` input 32: instruction word.
- `in_rs` input 32: value of register rs.
- `in_rt` input 32: value of register rt.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream consumes result.
- `out_data` output 32: shift result (0 when illegal).
- `out_rd` output 5: destination register, `instr[15:11]`.
- `out_illegal` output 1: instruction not a supported shift.
- `retired` output CNT_W: count of results consumed (`out_valid & out_ready`), illegal included.

## Operation

- Decode applies only when `instr[31:26]==0`. Funct and sub-field give `shift_op`:
  - 000000 sll: op 00, amount `shamt`.
  - 000010: srl (op 01) if `instr[21]==0`, rotr (op 11) if `instr[21]==1`; amount `shamt=instr[10:6]`.
  - 000011 sra: op 10, amount `shamt`.
  - 000100 sllv: op 00, amount `rs[4:0]`.
  - 000110: srlv (op 01) if `instr[6]==0`, rotrv (op 11) if `instr[6]==1`; amount `rs[4:0]`.
  - 000111 srav: op 10, amount `rs[4:0]`.
- Any other opcode or funct is illegal: `out_illegal=1`, `out_data=0`, and `out_rd` is still `instr[15:11]`. No other field checks are made; `sll $0,$0,0` (nop) is legal.
- Shifter data input is always `rt`. Variable amounts use only `rs[4:0]`; upper bits are ignored, so amount 36 behaves as 4.
- Stage 1 (decode register) holds `s1_valid`, op, amount, rt, rd and illegal. Decode logic is combinational before this register.
- Stage 2 (output register) holds `out_valid`, `out_data` (shifter output from stage-1 fields), `out_rd` and `out_illegal`.
- Advance rules:
  - `s2_adv = !out_valid | out_ready`
  - `s1_adv = !s1_valid | s2_adv`
  - `in_ready = s1_adv`
- `retired` increments on each `out_valid & out_ready` and wraps modulo 2^CNT_W.

## Timing

- Reset (async, `rst_n` low) clears `s1_valid`, `out_valid`, `out_data`, `out_rd`, `out_illegal` and `retired` to 0. `in_ready` reads 1 during and after reset.
- Latency: an instruction accepted at edge N appears with `out_valid=1` after edge N+1 (2-cycle accept-to-visible). Throughput is 1 per cycle with `out_ready` held high.
- Backpressure: when `out_valid & !out_ready`, the stage-2 contents hold stable. Stage 1 fills, then `in_ready` drops in the same cycle stage 1 is occupied and cannot advance. There are no bubbles and no data loss.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational path from input to output.
- `flush=1` at an edge clears `s1_valid` and `out_valid` and discards any instruction accepted that cycle. `retired` still counts a handshake completing in the same cycle. `flush` has priority over all other updates.
- Reset asserted mid-stream drops all in-flight instructions immediately. There is no partial output after `rst_n` rises.
- Counter wrap: `retired` goes from 2^CNT_W-1 to 0 with no flag.

## Test plan

- sll $3,$2,4 (`0x00021900`), rt=`0xcfcfcfcf`, `out_ready=1` → two cycles later `out_data=0xfcfcfcf0`, `out_rd=3`, `out_illegal=0`, `retired=1`.
- Back-to-back, one per cycle:
  - srl 8 (`0x00021a02`) → `0x00cfcfcf`
  - sra 12 (`0x00021b03`) → `0xfffcfcfc`
  - rotr 4 (`0x00221902`) → `0xfcfcfcfc`
  - Results arrive on three consecutive cycles; `in_ready` stays 1.
- srav $3,$2,$1 (`0x00221807`), rs=`0x00000024`, rt=`0xcfcfcfcf` → `0xfcfcfcfc` (amount masked to 4).
- Illegal funct `0x00221820` (add) → `out_illegal=1`, `out_data=0`, `out_rd=3`; `retired` increments when consumed.
- Backpressure: hold `out_ready=0` and issue 3 instructions.
  - Two are accepted, then `in_ready=0`; `out_data` is stable.
  - Release `out_ready`: all three emerge in order with no duplicates.
- Flush and reset:
  - With both stages full, `flush` for one cycle → `out_valid=0` next cycle and the next accepted instruction emerges normally.
  - With both stages full, pulse `rst_n` low mid-cycle → all outputs 0 immediately and `retired=0`.
